// File: rtl/instr_encoder.sv
// instr_encoder: packs ALU/memory instruction fields into 16-bit words and
// streams them to program memory at consecutive addresses. A small FIFO sits
// between field input and the registered memory write port so that write
// backpressure does not stall the loader every cycle.
module instr_encoder #(
   parameter int ADDR_W = 8,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        op_code,
   input  logic [3:0]        mem_op,
   input  logic [3:0]        left_operand,
   input  logic [3:0]        right_operand,
   input  logic              imm_sel,
   input  logic [7:0]        imm,
   input  logic              last,
   output logic              pm_we,
   input  logic              pm_ready,
   output logic [ADDR_W-1:0] pm_addr,
   output logic [15:0]       pm_wdata,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W:0]   count
);

   localparam int PW = $clog2(DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      DRAIN,
      FIN
   } state_t;

   state_t          state;
   logic [15:0]     fifo_mem [DEPTH];
   logic [PW:0]     wr_ptr;
   logic [PW:0]     rd_ptr;
   logic [ADDR_W:0] addr_cnt;
   logic [15:0]     new_word;
   logic            empty;
   logic            full;
   logic            push;
   logic            pop;

   // Pointers carry one extra wrap bit so full and empty can be told apart.
   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
   assign in_ready = (state == LOAD) && !full;
   assign push     = in_valid && in_ready;
   assign pop      = !empty && (!pm_we || pm_ready);

   // Assemble the instruction word from the field tuple presented this cycle.
   always_comb begin
      new_word = {op_code, mem_op, (imm_sel ? imm : {left_operand, right_operand})};
   end

   // FIFO storage; contents need no reset because the pointers define validity.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr[PW-1:0]] <= new_word;
      end
   end

   // FIFO pointers; push and pop in the same cycle are both honoured.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   // Registered write port, address counter, completion count and overflow flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         pm_we    <= 1'b0;
         pm_addr  <= '0;
         pm_wdata <= '0;
         addr_cnt <= '0;
         count    <= '0;
         err      <= 1'b0;
      end else begin
         if (state == IDLE && start) begin
            addr_cnt <= {1'b0, start_addr};
            count    <= '0;
            err      <= 1'b0;
         end
         if (pm_we && pm_ready) begin
            count <= count + 1'b1;
         end
         if (pop) begin
            if (addr_cnt[ADDR_W]) begin
               pm_we <= 1'b0;
               err   <= 1'b1;
            end else begin
               pm_we    <= 1'b1;
               pm_addr  <= addr_cnt[ADDR_W-1:0];
               pm_wdata <= fifo_mem[rd_ptr[PW-1:0]];
               addr_cnt <= addr_cnt + 1'b1;
            end
         end else if (pm_ready) begin
            pm_we <= 1'b0;
         end
      end
   end

   // Session sequencing with registered busy/done flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state <= LOAD;
                  busy  <= 1'b1;
               end
            end
            LOAD: begin
               if (push && last) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               if (empty && !pm_we) begin
                  state <= FIN;
                  done  <= 1'b1;
               end
            end
            FIN: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: table-driven, hand-sequenced and randomized sessions
// against a reference model of address assignment, overflow and encoding.
module tb_instr_encoder;

   localparam int ADDR_W = 8;
   localparam int DEPTH  = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [ADDR_W-1:0] start_addr;
   logic              in_valid;
   logic              in_ready;
   logic [3:0]        op_code;
   logic [3:0]        mem_op;
   logic [3:0]        left_operand;
   logic [3:0]        right_operand;
   logic              imm_sel;
   logic [7:0]        imm;
   logic              last;
   logic              pm_we;
   logic              pm_ready;
   logic [ADDR_W-1:0] pm_addr;
   logic [15:0]       pm_wdata;
   logic              busy;
   logic              done;
   logic              err;
   logic [ADDR_W:0]   count;

   typedef struct {
      logic [3:0] op;
      logic [3:0] mem;
      logic [3:0] l;
      logic [3:0] r;
      logic       isel;
      logic [7:0] imm;
   } tuple_t;

   typedef struct {
      tuple_t     t;
      logic [15:0] exp;
   } vec_t;

   int n_checks = 0;
   int n_fail   = 0;

   int          acc_cnt  = 0;
   int          done_cnt = 0;
   logic [23:0] got_q[$];

   int s_acc, s_got, s_done, s_sa;

   logic              prev_we;
   logic [ADDR_W-1:0] prev_addr;
   logic [15:0]       prev_data;

   instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
      .in_valid(in_valid), .in_ready(in_ready), .op_code(op_code), .mem_op(mem_op),
      .left_operand(left_operand), .right_operand(right_operand), .imm_sel(imm_sel),
      .imm(imm), .last(last), .pm_we(pm_we), .pm_ready(pm_ready), .pm_addr(pm_addr),
      .pm_wdata(pm_wdata), .busy(busy), .done(done), .err(err), .count(count)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Observe handshakes, completed writes and done pulses at each active edge.
   always @(posedge clk) begin
      if (!rst) begin
         if (in_valid && in_ready) acc_cnt = acc_cnt + 1;
         if (pm_we && pm_ready) got_q.push_back({pm_addr, pm_wdata});
         if (done) done_cnt = done_cnt + 1;
      end
   end

   // Global watchdog so the run can never hang.
   initial begin
      #3000000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [15:0] encode(input tuple_t t);
      return {t.op, t.mem, (t.isel ? t.imm : {t.l, t.r})};
   endfunction

   function automatic tuple_t rand_tuple();
      tuple_t t;
      t.op   = 4'($urandom);
      t.mem  = 4'($urandom);
      t.l    = 4'($urandom);
      t.r    = 4'($urandom);
      t.isel = 1'($urandom);
      t.imm  = 8'($urandom);
      return t;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks = n_checks + 1;
      if (act !== exp) begin
         n_fail = n_fail + 1;
         $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input tuple_t t, input logic v, input logic l);
      op_code       = t.op;
      mem_op        = t.mem;
      left_operand  = t.l;
      right_operand = t.r;
      imm_sel       = t.isel;
      imm           = t.imm;
      in_valid      = v;
      last          = l;
   endtask

   // Advance to the next falling edge; a write that was stalled on the last
   // edge must still be presented unchanged.
   task automatic tick();
      @(negedge clk);
      if (prev_we && !pm_ready && !rst) begin
         checkOutput("hold_we", 32'(pm_we), 32'd1);
         checkOutput("hold_addr", 32'(pm_addr), 32'(prev_addr));
         checkOutput("hold_data", 32'(pm_wdata), 32'(prev_data));
      end
      prev_we   = pm_we;
      prev_addr = pm_addr;
      prev_data = pm_wdata;
   endtask

   task automatic begin_session(input int sa);
      s_acc      = acc_cnt;
      s_got      = got_q.size();
      s_done     = done_cnt;
      s_sa       = sa;
      start      = 1'b1;
      start_addr = 8'(sa);
      in_valid   = 1'b0;
      tick();
      start = 1'b0;
   endtask

   // Feed the remaining tuples, drain, then compare against the model.
   task automatic finish_session(input tuple_t tq[$], input int ready_pct,
                                 input int valid_pct, input bit glitch);
      int          n;
      int          cyc;
      int          idx;
      int          a;
      int          nget;
      int          lim;
      logic        v;
      logic [23:0] expq[$];
      n   = tq.size();
      cyc = 0;
      while (busy && cyc < 3000) begin
         idx = acc_cnt - s_acc;
         v   = ($urandom_range(0, 99) < valid_pct);
         if (idx < n) applyStimulus(tq[idx], v, (idx == n - 1) || (!v && 1'($urandom)));
         else applyStimulus(rand_tuple(), 1'($urandom), 1'($urandom));
         pm_ready = ($urandom_range(0, 99) < ready_pct);
         if (glitch && cyc == 3) begin
            start      = 1'b1;
            start_addr = ~8'(s_sa);
         end else begin
            start = 1'b0;
         end
         tick();
         cyc = cyc + 1;
      end
      start    = 1'b0;
      in_valid = 1'b0;
      last     = 1'b0;
      checkOutput("session_timeout", 32'(busy), 32'd0);
      checkOutput("accepted", 32'(acc_cnt - s_acc), 32'(n));
      for (int i = 0; i < n; i++) begin
         a = s_sa + i;
         if (a < (1 << ADDR_W)) expq.push_back({8'(a), encode(tq[i])});
      end
      nget = got_q.size() - s_got;
      checkOutput("write_count", 32'(nget), 32'(expq.size()));
      lim = (nget < expq.size()) ? nget : expq.size();
      for (int i = 0; i < lim; i++) checkOutput("write", 32'(got_q[s_got + i]), 32'(expq[i]));
      checkOutput("count", 32'(count), 32'(expq.size()));
      checkOutput("err", 32'(err), 32'(expq.size() < n));
      checkOutput("done_pulses", 32'(done_cnt - s_done), 32'd1);
   endtask

   vec_t   vec[7];
   tuple_t tq[$];

   initial begin
      vec[0] = '{'{4'h1, 4'h2, 4'h3, 4'h4, 1'b0, 8'h00}, 16'h1234};
      vec[1] = '{'{4'h5, 4'h6, 4'h7, 4'h8, 1'b0, 8'h99}, 16'h5678};
      vec[2] = '{'{4'h9, 4'hA, 4'hB, 4'hC, 1'b0, 8'h00}, 16'h9ABC};
      vec[3] = '{'{4'hA, 4'h3, 4'hF, 4'h1, 1'b1, 8'h5C}, 16'hA35C};
      vec[4] = '{'{4'hA, 4'h3, 4'hF, 4'h1, 1'b0, 8'h5C}, 16'hA3F1};
      vec[5] = '{'{4'h0, 4'h0, 4'h7, 4'h7, 1'b1, 8'hFF}, 16'h00FF};
      vec[6] = '{'{4'hF, 4'hF, 4'hF, 4'hF, 1'b0, 8'h00}, 16'hFFFF};

      prev_we    = 1'b0;
      prev_addr  = '0;
      prev_data  = '0;
      rst        = 1'b1;
      start      = 1'b0;
      start_addr = '0;
      pm_ready   = 1'b0;
      applyStimulus(rand_tuple(), 1'b0, 1'b0);
      tick();
      tick();
      checkOutput("rst_we", 32'(pm_we), 32'd0);
      checkOutput("rst_addr", 32'(pm_addr), 32'd0);
      checkOutput("rst_data", 32'(pm_wdata), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_done", 32'(done), 32'd0);
      checkOutput("rst_err", 32'(err), 32'd0);
      checkOutput("rst_count", 32'(count), 32'd0);
      checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
      rst = 1'b0;
      tick();

      // Table sessions: first three words at 0x10, remaining four at 0x30.
      begin_session(32'h10);
      tq.delete();
      for (int i = 0; i < 3; i++) tq.push_back(vec[i].t);
      finish_session(tq, 100, 100, 1'b0);
      for (int i = 0; i < 3; i++) begin
         checkOutput("table_data", 32'(got_q[s_got + i][15:0]), 32'(vec[i].exp));
         checkOutput("table_addr", 32'(got_q[s_got + i][23:16]), 32'(32'h10 + i));
      end
      begin_session(32'h30);
      tq.delete();
      for (int i = 3; i < 7; i++) tq.push_back(vec[i].t);
      finish_session(tq, 100, 100, 1'b0);
      for (int i = 3; i < 7; i++) begin
         checkOutput("table_data", 32'(got_q[s_got + i - 3][15:0]), 32'(vec[i].exp));
         checkOutput("table_addr", 32'(got_q[s_got + i - 3][23:16]), 32'(32'h30 + i - 3));
      end

      // Backpressure: one word held on the port plus a full FIFO.
      tq.delete();
      for (int i = 0; i < 6; i++) tq.push_back(rand_tuple());
      begin_session(32'h20);
      for (int c = 0; c < 10; c++) begin
         applyStimulus(tq[(acc_cnt - s_acc) < 6 ? (acc_cnt - s_acc) : 5], 1'b1, 1'b0);
         pm_ready = 1'b0;
         tick();
      end
      checkOutput("bp_accepted", 32'(acc_cnt - s_acc), 32'd5);
      checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
      checkOutput("bp_we", 32'(pm_we), 32'd1);
      checkOutput("bp_addr", 32'(pm_addr), 32'h20);
      checkOutput("bp_data", 32'(pm_wdata), 32'(encode(tq[0])));
      finish_session(tq, 100, 100, 1'b0);

      // Overflow at the top of the address space, then START clears ERR.
      tq.delete();
      for (int i = 0; i < 3; i++) tq.push_back(rand_tuple());
      begin_session(32'hFE);
      finish_session(tq, 100, 100, 1'b0);
      checkOutput("ovf_err", 32'(err), 32'd1);
      tq.delete();
      tq.push_back(rand_tuple());
      begin_session(32'h00);
      checkOutput("err_cleared", 32'(err), 32'd0);
      finish_session(tq, 100, 100, 1'b0);

      // Reset mid-session with one word on the port and two in the FIFO.
      tq.delete();
      for (int i = 0; i < 3; i++) tq.push_back(rand_tuple());
      begin_session(32'h40);
      for (int c = 0; c < 3; c++) begin
         applyStimulus(tq[c], 1'b1, 1'b0);
         pm_ready = 1'b0;
         tick();
      end
      in_valid = 1'b0;
      checkOutput("abort_pre_we", 32'(pm_we), 32'd1);
      checkOutput("abort_pre_acc", 32'(acc_cnt - s_acc), 32'd3);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkOutput("abort_we", 32'(pm_we), 32'd0);
      checkOutput("abort_addr", 32'(pm_addr), 32'd0);
      checkOutput("abort_data", 32'(pm_wdata), 32'd0);
      checkOutput("abort_busy", 32'(busy), 32'd0);
      checkOutput("abort_in_ready", 32'(in_ready), 32'd0);
      checkOutput("abort_count", 32'(count), 32'd0);
      checkOutput("abort_no_write", 32'(got_q.size() - s_got), 32'd0);
      tick();
      tq.delete();
      for (int i = 0; i < 2; i++) tq.push_back(rand_tuple());
      begin_session(32'h80);
      finish_session(tq, 100, 100, 1'b0);

      // START pulsed mid-session must be ignored.
      tq.delete();
      for (int i = 0; i < 8; i++) tq.push_back(rand_tuple());
      begin_session(32'h50);
      finish_session(tq, 100, 100, 1'b1);

      // Randomized sessions, some near the top of the address space.
      for (int s = 0; s < 12; s++) begin
         int sa;
         int n;
         sa = (s % 2 == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(248, 255));
         n  = $urandom_range(1, 10);
         tq.delete();
         for (int i = 0; i < n; i++) tq.push_back(rand_tuple());
         begin_session(sa);
         finish_session(tq, $urandom_range(30, 100), $urandom_range(40, 100), 1'($urandom));
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Packs ALU/memory instruction fields into 16-bit instruction words and streams them into program memory at consecutive addresses.
- Bit layout is the inverse of the instruction decoder: [15:12] OP_CODE, [11:8] MEM_OP, [7:0] OPERAND, where OPERAND = {LEFT_OPERAND, RIGHT_OPERAND} or an 8-bit immediate.
- Sits between the test/boot loader and program memory.
- A small FIFO decouples field input from memory write backpressure.

Parameters:
- ADDR_W, 8: program memory address width.
- DEPTH, 4: FIFO depth in words. Power of two, >= 2.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- START  in  1  begin a load session; sampled in IDLE only.
- START_ADDR  in  ADDR_W  first program memory address, latched on START.
- IN_VALID  in  1  field tuple valid.
- IN_READY  out  1  encoder can accept a tuple.
- OP_CODE  in  4  ALU opcode.
- MEM_OP  in  4  memory operation.
- LEFT_OPERAND  in  4  destination / left operand.
- RIGHT_OPERAND  in  4  source / right operand.
- IMM_SEL  in  1  1 = OPERAND taken from IMM.
- IMM  in  8  immediate operand.
- LAST  in  1  qualifies the final tuple of the session.
- PM_WE  out  1  write request to program memory.
- PM_READY  in  1  memory accepts the write this cycle.
- PM_ADDR  out  ADDR_W  write address.
- PM_WDATA  out  16  encoded word.
- BUSY  out  1  state != IDLE.
- DONE  out  1  one-cycle pulse at session end.
- ERR  out  1  sticky address overflow; cleared by START or RST.
- COUNT  out  ADDR_W+1  words written this session.

Behaviour:
- Encoding: word = {OP_CODE, MEM_OP, IMM_SEL ? IMM : {LEFT_OPERAND, RIGHT_OPERAND}}. Fields are captured at the accept edge, i.e. when IN_VALID & IN_READY.
- FSM states:
  - IDLE: on START, latch START_ADDR into the address counter, clear COUNT and ERR, go to LOAD.
  - LOAD: on accepting a tuple with LAST=1, go to DRAIN.
  - DRAIN: when the FIFO is empty and PM_WE=0, go to FIN.
  - FIN: DONE=1 for one cycle, then IDLE.
- IN_READY = (state == LOAD) & FIFO not full. It does not depend on a same-cycle pop. It is 0 in IDLE, DRAIN and FIN.
- Output stage uses registered PM_WE/PM_ADDR/PM_WDATA:
  - Load from the FIFO head when the FIFO is non-empty and (PM_WE=0 or PM_READY=1). On load: PM_ADDR <= addr counter, addr counter increments, FIFO pops.
  - A write completes on an edge where PM_WE & PM_READY. COUNT increments on completion.
  - With no new load, PM_WE drops after completion.
  - PM_WE, PM_ADDR and PM_WDATA are held stable while PM_WE=1 and PM_READY=0.
- Latency: a tuple accepted at edge k into an empty FIFO with PM_WE=0 gives PM_WE=1 after edge k+1. Sustained throughput is 1 word/cycle with PM_READY held at 1.
- Overflow:
  - The address counter is ADDR_W+1 bits wide.
  - If its MSB is set at load time, the word is popped and discarded: no PM_WE, ERR <= 1, COUNT unchanged.
  - The session continues to DONE normally.
- Simultaneous events:
  - Push and pop in the same cycle are both performed.
  - START outside IDLE is ignored.
  - IN_VALID outside LOAD is ignored.
  - LAST=1 without IN_VALID has no effect.
- Reset values: state IDLE, FIFO empty, IN_READY=0, PM_WE=0, PM_ADDR=0, PM_WDATA=0, BUSY=0, DONE=0, ERR=0, COUNT=0.
- RST mid-session aborts on the same edge. Buffered words are discarded and a pending PM_WE is dropped.

Test Plan:
- START, START_ADDR=0x10. Send (1,2,3,4,IMM_SEL=0), (5,6,7,8), then (9,A,B,C) with LAST=1; PM_READY=1. Expected: writes 0x1234@0x10, 0x5678@0x11, 0x9ABC@0x12; DONE pulses once; COUNT=3; BUSY falls after FIN.
- OP=0xA, MEM=0x3, IMM_SEL=1, IMM=0x5C, L=0xF, R=0x1. Expected: PM_WDATA=0xA35C. Same tuple with IMM_SEL=0 gives 0xA3F1.
- PM_READY=0 for 10 cycles while IN_VALID=1 every cycle. Expected: 1 word held on outputs plus DEPTH=4 in the FIFO; IN_READY=0 from then on; PM outputs stable. Release PM_READY: 5 writes, in order, at consecutive addresses, with no loss or duplication.
- START_ADDR=0xFE (ADDR_W=8), 3 tuples, the last with LAST=1. Expected: writes at 0xFE and 0xFF; third word dropped; ERR=1; COUNT=2; DONE pulses. Next START clears ERR.
- RST asserted while PM_WE=1 and the FIFO holds 2 words. Expected: on the next edge all outputs return to reset values. A following START/LOAD session writes from its own START_ADDR with no stale words.
- START pulsed during LOAD with a different START_ADDR. Expected: ignored; addresses continue sequentially; exactly one DONE.
